mandelbrot_iterator: RTL and testbench

Per-pixel Mandelbrot iteration engine, the consumer side of the combinational `generator` block (a,b -> aa_minus_bb, two_ab, aa_plus_bb).
- Accepts a point c = (cr, ci) over a valid/ready handshake.
- Drives z = (a, b) into the generator and feeds its results back, one iteration per clock, adding c each time.
- Stops on escape or iteration limit and returns the iteration count over a valid/ready handshake.

---
 rtl/mandelbrot_iterator.sv | 129 ++++++++++++
 tb/tb_mandelbrot_iterator.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mandelbrot_iterator.sv
// Per-pixel Mandelbrot iteration engine driving an external combinational generator.
// Optional `abort` input is enabled by defining MANDEL_ABORT_EN.
module mandelbrot_iterator #(
  parameter int unsigned MAX_ITER = 255,
  parameter int unsigned ITER_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
`ifdef MANDEL_ABORT_EN
  input  logic              abort,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       cr,
  input  logic [31:0]       ci,
  output logic [31:0]       gen_a,
  output logic [31:0]       gen_b,
  input  logic [31:0]       gen_aa_minus_bb,
  input  logic [31:0]       gen_two_ab,
  input  logic [31:0]       gen_aa_plus_bb,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ITER_W-1:0] count,
  output logic              escaped
);

  localparam logic signed [31:0] POS_TWO  = 32'sh2000_0000;
  localparam logic signed [31:0] NEG_TWO  = 32'shE000_0000;
  localparam logic        [31:0] FOUR     = 32'h4000_0000;
  localparam logic [ITER_W-1:0]  MAX_CNT  = ITER_W'(MAX_ITER);

  typedef enum logic [1:0] {
    IDLE,
    ITERATE,
    DONE
  } state_t;

  state_t            state, state_nxt;
  logic [31:0]       a, b, a_nxt, b_nxt;
  logic [31:0]       cr_q, ci_q, cr_nxt, ci_nxt;
  logic [ITER_W-1:0] iter, iter_nxt, count_nxt;
  logic              escaped_nxt;
  logic              esc;

  function automatic logic mag_ge_two(input logic [31:0] x);
    mag_ge_two = ($signed(x) >= POS_TWO) || ($signed(x) <= NEG_TWO);
  endfunction

  assign gen_a     = a;
  assign gen_b     = b;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // The |a|,|b| guard keeps aa_plus_bb below 8.0, so an unsigned compare is safe.
  assign esc = mag_ge_two(a) || mag_ge_two(b) || (gen_aa_plus_bb >= FOUR);

  always_comb begin
    state_nxt   = state;
    a_nxt       = a;
    b_nxt       = b;
    cr_nxt      = cr_q;
    ci_nxt      = ci_q;
    iter_nxt    = iter;
    count_nxt   = count;
    escaped_nxt = escaped;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          cr_nxt    = cr;
          ci_nxt    = ci;
          a_nxt     = '0;
          b_nxt     = '0;
          iter_nxt  = '0;
          state_nxt = ITERATE;
        end
      end
      ITERATE: begin
        if (esc) begin
          count_nxt   = iter;
          escaped_nxt = 1'b1;
          state_nxt   = DONE;
        end else if (iter == MAX_CNT) begin
          count_nxt   = MAX_CNT;
          escaped_nxt = 1'b0;
          state_nxt   = DONE;
        end else begin
          a_nxt    = gen_aa_minus_bb + cr_q;
          b_nxt    = gen_two_ab + ci_q;
          iter_nxt = iter + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
`ifdef MANDEL_ABORT_EN
    // Abort wins over escape and out_ready; the previous result stays untouched.
    if (abort && state != IDLE) begin
      state_nxt   = IDLE;
      count_nxt   = count;
      escaped_nxt = escaped;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a       <= '0;
      b       <= '0;
      cr_q    <= '0;
      ci_q    <= '0;
      iter    <= '0;
      count   <= '0;
      escaped <= 1'b0;
    end else begin
      state   <= state_nxt;
      a       <= a_nxt;
      b       <= b_nxt;
      cr_q    <= cr_nxt;
      ci_q    <= ci_nxt;
      iter    <= iter_nxt;
      count   <= count_nxt;
      escaped <= escaped_nxt;
    end
  end

endmodule

// File: tb/tb_mandelbrot_iterator.sv
// Directed self-checking bench for mandelbrot_iterator with a behavioural Q4.28 generator.
module tb_mandelbrot_iterator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] cr, ci;
  logic [31:0] gen_a, gen_b;
  logic [31:0] gen_aa_minus_bb, gen_two_ab, gen_aa_plus_bb;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] count;
  logic        escaped;
`ifdef MANDEL_ABORT_EN
  logic        abort;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mandelbrot_iterator #(.MAX_ITER(255), .ITER_W(16)) dut (
    .clk             (clk),
    .rst             (rst),
`ifdef MANDEL_ABORT_EN
    .abort           (abort),
`endif
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .cr              (cr),
    .ci              (ci),
    .gen_a           (gen_a),
    .gen_b           (gen_b),
    .gen_aa_minus_bb (gen_aa_minus_bb),
    .gen_two_ab      (gen_two_ab),
    .gen_aa_plus_bb  (gen_aa_plus_bb),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .count           (count),
    .escaped         (escaped)
  );

  // Q4.28 squares and cross product, truncated back to 32 bits.
  logic signed [63:0] p_aa, p_bb, p_ab;
  logic [31:0] aa, bb;
  always_comb begin
    p_aa = 64'($signed(gen_a)) * 64'($signed(gen_a));
    p_bb = 64'($signed(gen_b)) * 64'($signed(gen_b));
    p_ab = 64'($signed(gen_a)) * 64'($signed(gen_b));
    aa = p_aa[59:28];
    bb = p_bb[59:28];
    gen_aa_minus_bb = aa - bb;
    gen_two_ab      = p_ab[58:27];
    gen_aa_plus_bb  = aa + bb;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept a point and wait (bounded) for out_valid; lat counts edges from the accept edge.
  task automatic run_point(input logic [31:0] pr, input logic [31:0] pi, output int lat);
    in_valid = 1'b1;
    cr = pr;
    ci = pi;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 400) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    int lat;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || count !== 16'd0 || escaped !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b count=%0d escaped=%b, want 1 0 0 0",
               in_ready, out_valid, count, escaped);
    end
    lat = 0;
  endtask

  task automatic test_escape_neg_two();
    int lat;
    run_point(32'hE000_0000, 32'h0, lat);
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL neg2_latency: got %0d want 3", lat);
    end
    checks++;
    if (count !== 16'd1 || escaped !== 1'b1) begin
      errors++;
      $display("FAIL neg2_result: count=%0d escaped=%b want 1 1", count, escaped);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || count !== 16'd1) begin
      errors++;
      $display("FAIL neg2_release: out_valid=%b in_ready=%b count=%0d want 0 1 1",
               out_valid, in_ready, count);
    end
  endtask

  task automatic test_reset_mid_iterate();
    in_valid = 1'b1;
    cr = 32'h0;
    ci = 32'h0;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_iter_busy: in_ready=%b out_valid=%b want 0 0", in_ready, out_valid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || count !== 16'd0 || escaped !== 1'b0) begin
      errors++;
      $display("FAIL mid_iter_reset: in_ready=%b out_valid=%b count=%0d escaped=%b want 1 0 0 0",
               in_ready, out_valid, count, escaped);
    end
    repeat (3) tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_iter_discard: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_escape_magnitude();
    int lat;
    run_point(32'h1800_0000, 32'h0, lat);
    checks++;
    if (lat !== 4 || count !== 16'd2 || escaped !== 1'b1) begin
      errors++;
      $display("FAIL c1p5: lat=%0d count=%0d escaped=%b want 4 2 1", lat, count, escaped);
    end
    tick();
  endtask

  task automatic test_max_iter();
    int lat;
    run_point(32'h0, 32'h1000_0000, lat);
    checks++;
    if (lat !== 257) begin
      errors++;
      $display("FAIL max_iter_latency: got %0d want 257", lat);
    end
    checks++;
    if (count !== 16'd255 || escaped !== 1'b0) begin
      errors++;
      $display("FAIL max_iter_result: count=%0d escaped=%b want 255 0", count, escaped);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat;
    out_ready = 1'b0;
    run_point(32'hE000_0000, 32'h0, lat);
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL bp_latency: got %0d want 3", lat);
    end
    // Hold a second point on the input; it must be ignored while DONE.
    in_valid = 1'b1;
    cr = 32'h1800_0000;
    ci = 32'h0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || count !== 16'd1 || escaped !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: out_valid=%b count=%0d escaped=%b in_ready=%b want 1 1 1 0",
                 i, out_valid, count, escaped, in_ready);
      end
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 400) begin
      tick();
      lat++;
    end
    checks++;
    if (lat !== 4 || count !== 16'd2 || escaped !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second: lat=%0d count=%0d escaped=%b want 4 2 1", lat, count, escaped);
    end
    tick();
  endtask

`ifdef MANDEL_ABORT_EN
  task automatic test_abort();
    int lat;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_idle: in_ready=%b want 1", in_ready);
    end
    in_valid = 1'b1;
    cr = 32'h0;
    ci = 32'h0;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_iter: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    run_point(32'hE000_0000, 32'h0, lat);
    checks++;
    if (lat !== 3 || count !== 16'd1 || escaped !== 1'b1) begin
      errors++;
      $display("FAIL abort_next: lat=%0d count=%0d escaped=%b want 3 1 1", lat, count, escaped);
    end
    tick();
  endtask
`endif

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    cr = '0;
    ci = '0;
    out_ready = 1'b1;
`ifdef MANDEL_ABORT_EN
    abort = 1'b0;
`endif
    test_reset();
    test_escape_neg_two();
    test_reset_mid_iterate();
    test_escape_magnitude();
    test_max_iter();
    test_back_to_back();
`ifdef MANDEL_ABORT_EN
    test_abort();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
